// File: rtl/mssd_serial_tx_if.sv
// -----------------------------------------------------------------------------
// mssd_serial_tx_if
// Signal bundle between the host-side packet source (master) and the MSSD
// serial transmitter (slave).
//   frame_valid/frame_ready, port[1:0], len[5:0] : frame command channel
//   data_valid/data_ready, data[7:0]             : payload byte channel
//   ser_out                                       : serial line (registered)
//   busy, done, underrun, len_err                 : status / event pulses
//   state_dbg[2:0]                                : transmitter FSM state
// Handshake rule for both channels: a transfer happens at the rising clk edge
// where valid and ready are both 1. ready never depends on valid; the master
// holds its payload stable while valid is high and not yet taken.
// -----------------------------------------------------------------------------
interface mssd_serial_tx_if;
  logic       frame_valid;
  logic       frame_ready;
  logic [1:0] port;
  logic [5:0] len;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] data;
  logic       ser_out;
  logic       busy;
  logic       done;
  logic       underrun;
  logic       len_err;
  logic [2:0] state_dbg;

  modport master (
    output frame_valid, port, len, data_valid, data,
    input  frame_ready, data_ready, ser_out, busy, done, underrun, len_err, state_dbg
  );

  modport slave (
    input  frame_valid, port, len, data_valid, data,
    output frame_ready, data_ready, ser_out, busy, done, underrun, len_err, state_dbg
  );
endinterface

// File: rtl/mssd_serial_tx.sv
// -----------------------------------------------------------------------------
// mssd_serial_tx
// Serial frame transmitter for the MSSD link. One bit per clk:
//   idle-1, start-0, port[1:0], len[5:0], len data bytes, stop-1 (LSB first).
// Ports:
//   clk  : clock, one serial bit per cycle
//   rst  : asynchronous, active-high reset
//   bus  : mssd_serial_tx_if.slave (frame command, payload bytes, ser_out,
//          busy/done/underrun/len_err status, state_dbg FSM state)
// Build option: define MSSD_TX_GAP_EN to insert IDLE_GAP idle bits after each
// stop bit (frame_ready held low until the gap is over).
// -----------------------------------------------------------------------------
module mssd_serial_tx #(
  parameter logic [3:0] IDLE_GAP = 4'd2
) (
  input  logic            clk,
  input  logic            rst,
  mssd_serial_tx_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_HDR   = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
`ifdef MSSD_TX_GAP_EN
    , ST_GAP = 3'd5
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] byte_cnt_q, byte_cnt_d;
  logic [5:0] fetched_q, fetched_d;
  logic [5:0] len_q, len_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       ser_out_q, ser_out_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;
  logic       len_err_q, len_err_d;
`ifdef MSSD_TX_GAP_EN
  logic [3:0] gap_cnt_q, gap_cnt_d;
`else
  logic       unused_idle_gap;
  assign unused_idle_gap = ^IDLE_GAP;
`endif

  logic frame_ready, frame_acc, data_ready, data_acc, in_frame, slot_load;

`ifdef MSSD_TX_GAP_EN
  assign frame_ready = (state_q == ST_IDLE);
`else
  // Accepting in STOP lets the next start bit follow the stop bit directly.
  assign frame_ready = (state_q == ST_IDLE) || (state_q == ST_STOP);
`endif
  assign in_frame   = (state_q == ST_START) || (state_q == ST_HDR) || (state_q == ST_DATA);
  assign data_ready = !hold_full_q && in_frame && (fetched_q < len_q);
  assign frame_acc  = bus.frame_valid && frame_ready;
  assign data_acc   = bus.data_valid && data_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    fetched_d   = fetched_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    len_err_d   = 1'b0;
    slot_load   = 1'b0;
`ifdef MSSD_TX_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif

    if (data_acc) begin
      hold_d      = bus.data;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 6'd1;
    end

    case (state_q)
      ST_START: state_d = ST_HDR;
      ST_HDR: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d    = ST_DATA;
          byte_cnt_d = 6'd0;
          slot_load  = 1'b1;
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      ST_DATA: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q == len_q - 6'd1) begin
            state_d = ST_STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
            slot_load  = 1'b1;
          end
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
`ifdef MSSD_TX_GAP_EN
      // The IDLE cycle after GAP is itself an idle bit, so GAP lasts
      // IDLE_GAP-1 cycles to give IDLE_GAP idle bits before the next start.
      ST_STOP: begin
        gap_cnt_d = 4'd0;
        state_d   = (IDLE_GAP > 4'd1) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == IDLE_GAP - 4'd2) state_d = ST_IDLE;
        else                              gap_cnt_d = gap_cnt_q + 4'd1;
      end
`else
      ST_STOP: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Byte boundary: take the held byte, else forward a byte arriving this
    // edge, else send 0x00. A missed slot is counted as fetched so a late
    // byte can never be accepted beyond the slots still left in the frame.
    if (slot_load) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else if (data_acc) begin
        shift_d     = bus.data;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = 8'h00;
        underrun_d = 1'b1;
        fetched_d  = fetched_q + 6'd1;
      end
    end

    if (frame_acc) begin
      if (bus.len == 6'd0) begin
        len_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        state_d     = ST_START;
        shift_d     = {bus.len, bus.port};
        len_d       = bus.len;
        fetched_d   = 6'd0;
        hold_full_d = 1'b0;
        bit_cnt_d   = 3'd0;
        byte_cnt_d  = 6'd0;
      end
    end

    // Line value for the state being entered, so ser_out leaves a flop.
    case (state_d)
      ST_START:        ser_out_d = 1'b0;
      ST_HDR, ST_DATA: ser_out_d = shift_d[0];
      default:         ser_out_d = 1'b1;
    endcase
    done_d = (state_d == ST_STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 6'd0;
      fetched_q   <= 6'd0;
      len_q       <= 6'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      ser_out_q   <= 1'b1;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      len_err_q   <= 1'b0;
`ifdef MSSD_TX_GAP_EN
      gap_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      fetched_q   <= fetched_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ser_out_q   <= ser_out_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      len_err_q   <= len_err_d;
`ifdef MSSD_TX_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign bus.frame_ready = frame_ready;
  assign bus.data_ready  = data_ready;
  assign bus.ser_out     = ser_out_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.underrun    = underrun_q;
  assign bus.len_err     = len_err_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mssd_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_mssd_serial_tx
// Directed bench for mssd_serial_tx. Inputs change and outputs are sampled on
// the falling clk edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mssd_serial_tx;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef MSSD_TX_GAP_EN
  localparam int GAP_BITS = 2;
`else
  localparam int GAP_BITS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mssd_serial_tx_if bus ();

  mssd_serial_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [0:0] exp_q[$];
  logic [0:0] bits_q[$];
  logic [7:0] byte_tbl[16];
  int         hs_cnt, und_cnt, und_at, done_cnt, done_at, busy_cnt;
  bit         timed_out;

  // Reference frame builder: start, port, len, bytes, stop, each LSB first.
  task automatic model_frame(input logic [1:0] p, input logic [5:0] l, input int first);
    logic [7:0] b;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) exp_q.push_back(p[i]);
    for (int i = 0; i < 6; i++) exp_q.push_back(l[i]);
    for (int k = 0; k < int'(l); k++) begin
      b = byte_tbl[first + k];
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    end
    exp_q.push_back(1'b1);
  endtask

  // ---------------- driver ----------------
  // Issues one frame command, offers byte_tbl[0..n_offer-1] and records the
  // serial line for every cycle busy is high. Called at a falling edge.
  task automatic run_frame(input logic [1:0] p, input logic [5:0] l, input int n_offer,
                           input int budget);
    int idx;
    bit acc, started, finished;
    bits_q.delete();
    hs_cnt = 0; und_cnt = 0; und_at = -1; done_cnt = 0; done_at = -1; busy_cnt = 0;
    idx = 0; acc = 0; started = 0; finished = 0;
    bus.frame_valid = 1'b1;
    bus.port        = p;
    bus.len         = l;
    for (int cyc = 0; cyc < budget; cyc++) begin
      bus.data_valid = (idx < n_offer);
      bus.data       = byte_tbl[idx];
      if (bus.frame_valid && bus.frame_ready) acc = 1;
      if (bus.data_valid && bus.data_ready) begin
        idx++;
        hs_cnt++;
      end
      @(negedge clk);
      if (acc) bus.frame_valid = 1'b0;
      if (acc && bus.busy) begin
        started = 1;
        busy_cnt++;
        bits_q.push_back(bus.ser_out);
        if (bus.done) begin done_cnt++; done_at = bits_q.size() - 1; end
        if (bus.underrun) begin und_cnt++; und_at = bits_q.size() - 1; end
      end else if (started) begin
        finished = 1;
        break;
      end
    end
    bus.data_valid = 1'b0;
    bus.frame_valid = 1'b0;
    timed_out = !finished;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.frame_valid = 1'b0; bus.port = 2'b00; bus.len = 6'd0;
    bus.data_valid = 1'b0; bus.data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.ser_out !== 1'b1) begin failures++; $display("FAIL reset_ser_out got=%b exp=1", bus.ser_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", bus.underrun); end
    checks++; if (bus.len_err !== 1'b0) begin failures++; $display("FAIL reset_len_err got=%b exp=0", bus.len_err); end
    checks++; if (bus.frame_ready !== 1'b1) begin failures++; $display("FAIL reset_frame_ready got=%b exp=1", bus.frame_ready); end
    checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready got=%b exp=0", bus.data_ready); end
    checks++; if (bus.state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, S_IDLE); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ser_out !== 1'b1) begin failures++; $display("FAIL idle_ser_out got=%b exp=1", bus.ser_out); end
  endtask

  task automatic test_single_byte();
    logic [17:0] vec;
    int          bad;
    vec = 18'b001100000101001011;   // first serial bit is the MSB here
    byte_tbl[0] = 8'hA5;
    run_frame(2'b10, 6'd1, 1, 60);
    checks++; if (timed_out) begin failures++; $display("FAIL t1_timeout got=1 exp=0"); end
    checks++; if (busy_cnt != 18) begin failures++; $display("FAIL t1_busy_cycles got=%0d exp=18", busy_cnt); end
    bad = -1;
    for (int i = 0; i < 18; i++)
      if (bad < 0 && (i >= bits_q.size() || bits_q[i] !== vec[17-i])) bad = i;
    checks++; if (bad >= 0) begin failures++; $display("FAIL t1_bits first_bad_index got=%0d exp=none", bad); end
    checks++; if (done_cnt != 1 || done_at != 17) begin failures++; $display("FAIL t1_done got=%0d@%0d exp=1@17", done_cnt, done_at); end
    checks++; if (und_cnt != 0) begin failures++; $display("FAIL t1_underrun got=%0d exp=0", und_cnt); end
    checks++; if (hs_cnt != 1) begin failures++; $display("FAIL t1_handshakes got=%0d exp=1", hs_cnt); end
    checks++; if (bus.ser_out !== 1'b1) begin failures++; $display("FAIL t1_idle_after got=%b exp=1", bus.ser_out); end
  endtask

  task automatic test_multi_byte();
    logic [1:0] rx_port;
    logic [5:0] rx_len;
    logic [7:0] rx_b, want;
    byte_tbl[0] = 8'h11; byte_tbl[1] = 8'h22; byte_tbl[2] = 8'h33; byte_tbl[3] = 8'h44;
    run_frame(2'b01, 6'd3, 4, 100);
    checks++; if (timed_out) begin failures++; $display("FAIL t2_timeout got=1 exp=0"); end
    checks++; if (hs_cnt != 3) begin failures++; $display("FAIL t2_handshakes got=%0d exp=3", hs_cnt); end
    checks++; if (busy_cnt != 34) begin failures++; $display("FAIL t2_busy_cycles got=%0d exp=34", busy_cnt); end
    checks++; if (und_cnt != 0) begin failures++; $display("FAIL t2_underrun got=%0d exp=0", und_cnt); end
    while (bits_q.size() < 34) bits_q.push_back(1'bx);
    // Receiver model: decode the captured line independently.
    rx_port = {bits_q[2], bits_q[1]};
    for (int i = 0; i < 6; i++) rx_len[i] = bits_q[3+i];
    checks++; if (bits_q[0] !== 1'b0 || bits_q[33] !== 1'b1) begin failures++; $display("FAIL t2_framing got=%b/%b exp=0/1", bits_q[0], bits_q[33]); end
    checks++; if (rx_port !== 2'b01) begin failures++; $display("FAIL t2_port got=%b exp=01", rx_port); end
    checks++; if (rx_len !== 6'd3) begin failures++; $display("FAIL t2_len got=%0d exp=3", rx_len); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) rx_b[i] = bits_q[9 + 8*k + i];
      want = 8'h11 * 8'(k + 1);
      checks++; if (rx_b !== want) begin failures++; $display("FAIL t2_byte%0d got=%h exp=%h", k, rx_b, want); end
    end
  endtask

  task automatic test_underrun();
    int bad;
    byte_tbl[0] = 8'h3C;
    run_frame(2'b11, 6'd2, 1, 100);
    checks++; if (timed_out) begin failures++; $display("FAIL t3_timeout got=1 exp=0"); end
    checks++; if (busy_cnt != 26) begin failures++; $display("FAIL t3_busy_cycles got=%0d exp=26", busy_cnt); end
    checks++; if (und_cnt != 1 || und_at != 17) begin failures++; $display("FAIL t3_underrun got=%0d@%0d exp=1@17", und_cnt, und_at); end
    checks++; if (hs_cnt != 1) begin failures++; $display("FAIL t3_handshakes got=%0d exp=1", hs_cnt); end
    byte_tbl[1] = 8'h00;
    exp_q.delete();
    model_frame(2'b11, 6'd2, 0);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= bits_q.size() || bits_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0) begin failures++; $display("FAIL t3_bits first_bad_index got=%0d exp=none", bad); end
  endtask

  task automatic test_len_zero();
    int  lerr_cnt;
    bit  low_seen, busy_seen, rdy_lost;
    bus.frame_valid = 1'b1; bus.port = 2'b01; bus.len = 6'd0;
    checks++; if (bus.frame_ready !== 1'b1) begin failures++; $display("FAIL t4_ready_before got=%b exp=1", bus.frame_ready); end
    @(negedge clk);
    bus.frame_valid = 1'b0;
    checks++; if (bus.len_err !== 1'b1) begin failures++; $display("FAIL t4_len_err got=%b exp=1", bus.len_err); end
    lerr_cnt = 0; low_seen = 0; busy_seen = 0; rdy_lost = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.len_err) lerr_cnt++;
      if (bus.ser_out !== 1'b1) low_seen = 1;
      if (bus.busy !== 1'b0) busy_seen = 1;
      if (bus.frame_ready !== 1'b1) rdy_lost = 1;
      @(negedge clk);
    end
    checks++; if (lerr_cnt != 1) begin failures++; $display("FAIL t4_len_err_pulses got=%0d exp=1", lerr_cnt); end
    checks++; if (low_seen) begin failures++; $display("FAIL t4_ser_out_low got=1 exp=0"); end
    checks++; if (busy_seen) begin failures++; $display("FAIL t4_busy got=1 exp=0"); end
    checks++; if (rdy_lost) begin failures++; $display("FAIL t4_frame_ready_drop got=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    int n_acc, idx, bad;
    byte_tbl[0] = 8'h81; byte_tbl[1] = 8'h7E;
    exp_q.delete();
    model_frame(2'b01, 6'd1, 0);
    for (int i = 0; i < GAP_BITS; i++) exp_q.push_back(1'b1);
    model_frame(2'b11, 6'd1, 1);
    bits_q.delete(); done_cnt = 0; n_acc = 0; idx = 0;
    bus.frame_valid = 1'b1; bus.port = 2'b01; bus.len = 6'd1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      bus.data_valid = (idx < 2);
      bus.data       = byte_tbl[idx];
      if (bus.frame_valid && bus.frame_ready) n_acc++;
      if (bus.data_valid && bus.data_ready) idx++;
      @(negedge clk);
      if (n_acc == 1) bus.port = 2'b11;
      if (n_acc == 2) bus.frame_valid = 1'b0;
      if (n_acc >= 1) begin
        bits_q.push_back(bus.ser_out);
        if (bus.done) done_cnt++;
      end
      if (bits_q.size() == exp_q.size()) break;
    end
    bus.data_valid = 1'b0; bus.frame_valid = 1'b0;
    checks++; if (n_acc != 2) begin failures++; $display("FAIL t5_accepts got=%0d exp=2", n_acc); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL t5_done got=%0d exp=2", done_cnt); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= bits_q.size() || bits_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0) begin failures++; $display("FAIL t5_bits first_bad_index got=%0d exp=none", bad); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.ser_out !== 1'b1) begin failures++; $display("FAIL t5_idle_after got=%b/%b exp=0/1", bus.busy, bus.ser_out); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bus.frame_valid = 1'b1; bus.port = 2'b10; bus.len = 6'd2;
    bus.data_valid = 1'b1; bus.data = 8'hC3;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (bus.state_dbg !== S_DATA) begin failures++; $display("FAIL t6_in_data got=%0d exp=%0d", bus.state_dbg, S_DATA); end
    bus.data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.ser_out !== 1'b1) begin failures++; $display("FAIL t6_async_ser_out got=%b exp=1", bus.ser_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t6_async_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL t6_data_ready_idle got=%b exp=0", bus.data_ready); end
    byte_tbl[0] = 8'h5A;
    run_frame(2'b01, 6'd1, 1, 60);
    exp_q.delete();
    model_frame(2'b01, 6'd1, 0);
    checks++; if (timed_out || busy_cnt != 18) begin failures++; $display("FAIL t6_next_frame_len got=%0d exp=18", busy_cnt); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= bits_q.size() || bits_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0) begin failures++; $display("FAIL t6_next_frame_bits first_bad_index got=%0d exp=none", bad); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 16; i++) byte_tbl[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_underrun();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
